sme_multi: RTL
==============

Name: sme_multi

Overview:
- Parametrised string-matching engine. Stores one string, then evaluates any number of patterns against it without the string being reloaded.
- Patterns may contain the metacharacters '^', '$', '.' and '*'.
- For each pattern the block reports a match/no-match result and the leftmost match index.
- Sits behind the character-stream front end. Results are consumed by the host-side result collector.

Parameters:
- CHAR_W, 8, character width in bits; metacharacter codes are compared in the low 8 bits.
- STR_MAX, 32, maximum stored string length.
- PAT_MAX, 8, maximum stored pattern length, including metacharacters.
- IDX_W, $clog2(STR_MAX), width of match_index.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- chardata  in  CHAR_W  input character
- isstring  in  1  chardata is a string character this cycle
- ispattern  in  1  chardata is a pattern character this cycle
- valid  out  1  one-cycle result strobe
- match  out  1  pattern matched; qualified by valid
- match_index  out  IDX_W  start index of leftmost match; qualified by valid
- busy  out  1  high from the end of a pattern until valid

Behaviour:
- Reset (asynchronous): state IDLE; valid=0, match=0, match_index=0, busy=0; str_len=0, pat_len=0. The stored string is cleared, and any operation in progress is abandoned with no valid.
- Outputs are registered. match and match_index are 0 whenever valid=0.
- States: IDLE, LD_STR, LD_PAT, SCAN, SEEK, DONE.
- IDLE:
  - isstring -> LD_STR; the string buffer is cleared and the first char is written at index 0.
  - else ispattern -> LD_PAT; the first pattern char is written.
- LD_STR: each isstring cycle appends one char. On the first cycle without isstring -> IDLE, or LD_PAT if ispattern is high that cycle.
- LD_PAT: each ispattern cycle appends one char. On the first cycle without ispattern -> SCAN with busy=1.
- Both isstring and ispattern high in the same cycle: isstring wins and the pattern char is dropped.
- Overflow: chars beyond STR_MAX/PAT_MAX are dropped and the length saturates.
- A new string burst replaces the stored string. Patterns with no preceding string give valid with match=0.
- Metacharacter semantics:
  - '.' (0x2E): any single char.
  - '^' (0x5E, pattern position 0 only): the match start s must satisfy s==0 or str[s-1]==0x20. Consumes no char.
  - '$' (0x24, last pattern position only): the match end e must satisfy e==str_len or str[e]==0x20. Consumes no char.
  - '*' (0x2A, at most one per pattern): any sequence of zero or more chars.
- Matching:
  - The pattern is split at '*' into a prefix P and a suffix Q.
  - SCAN: for s = 0..str_len-1, compare P at s, one char per cycle. Any mismatch advances s and restarts P.
  - If P matches and there is no '*': -> DONE with match=1.
  - If P matches and there is a '*': -> SEEK, which searches Q at positions t >= s+|P| (one char per cycle, leftmost first). If Q is found -> DONE with match=1, match_index=s. If Q is exhausted -> back to SCAN at s+1.
  - s exhausted -> DONE with match=0.
- Empty P (pattern begins with '*', or is "^*"): matches at s=0 and, with '^', satisfies the anchor.
- DONE: valid=1 for exactly one cycle; busy drops in the same cycle; -> IDLE.
- Latency: pattern end to valid ≤ 2*STR_MAX*PAT_MAX+4 cycles.
- isstring/ispattern are ignored while busy=1; upstream must not drive them then.
- Index arithmetic is IDX_W+1 bits to avoid wrap at STR_MAX.

Optional Feature:
- Macro: SME_NOCASE_EN.
- Defined: comparisons of string chars against pattern literals fold 0x41-0x5A to 0x61-0x7A on both operands before comparing. Metacharacter decoding is unaffected.
- Undefined: comparison is exact, case-sensitive.

Test Plan:
- String "the cat sat" (len 11), pattern "c.t" -> valid after ≤ 2*STR_MAX*PAT_MAX+4 cycles, match=1, match_index=4.
- Same string retained, patterns "^sat" then "sat$" then "dog" -> (1,8), (1,8), (0,0); one valid pulse per pattern, busy high between.
- String "the cat", pattern "^t*t$" -> match=1, match_index=0. Pattern "^a*" -> match=0.
- Load 40 chars with STR_MAX=32, pattern "^" followed by the first 7 chars -> match=1, match_index=0. Chars 33-40 are ignored and str_len=32.
- Assert reset during SEEK -> no valid ever appears for that pattern. Pattern "x" issued with no string loaded -> valid with match=0.
- With SME_NOCASE_EN: string "Hello", pattern "hE.LO" -> match=1, match_index=0. Without the macro -> match=0.

Source files
------------

// File: rtl/sme_multi.sv
// String-matching engine: holds one string, matches patterns with ^ $ . * against it.
// Define SME_NOCASE_EN for case-insensitive literal comparison.
module sme_multi #(
    parameter int CHAR_W  = 8,
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int IDX_W   = $clog2(STR_MAX)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CHAR_W-1:0] chardata,
    input  logic              isstring,
    input  logic              ispattern,
    output logic              valid,
    output logic              match,
    output logic [IDX_W-1:0]  match_index,
    output logic              busy
);
    localparam int IW   = IDX_W + 1;
    localparam int PI_W = $clog2(PAT_MAX);
    localparam int PK_W = PI_W + 1;

    typedef enum logic [2:0] {IDLE, LD_STR, LD_PAT, SCAN, SEEK, DONE} state_t;

    state_t            state_q;
    logic [CHAR_W-1:0] str_q [STR_MAX];
    logic [CHAR_W-1:0] pat_q [PAT_MAX];
    logic [IW-1:0]     str_len_q, s_q, t_q;
    logic [PK_W-1:0]   pat_len_q, k_q;
    logic              valid_q, match_q, busy_q;
    logic [IDX_W-1:0]  idx_q;

    logic              caret, dollar, has_star, char_ok, start_ok, end_ok;
    logic [PK_W-1:0]   last, star_pos, p_lo, p_hi, q_lo, q_hi, lo, off;
    logic [IW-1:0]     base, pos;
    logic [IDX_W-1:0]  s_m1;
    logic [CHAR_W-1:0] str_c, pat_c, prev_c;

    function automatic logic [CHAR_W-1:0] fold(input logic [CHAR_W-1:0] c);
`ifdef SME_NOCASE_EN
        if (c >= CHAR_W'(8'h41) && c <= CHAR_W'(8'h5A)) return c | CHAR_W'(8'h20);
`endif
        return c;
    endfunction

    always_comb begin
        last     = pat_len_q - PK_W'(1);
        caret    = (pat_len_q != '0) && (pat_q[0][7:0] == 8'h5E);
        dollar   = (pat_len_q != '0) && (pat_q[last[PI_W-1:0]][7:0] == 8'h24);
        has_star = 1'b0;
        star_pos = '0;
        for (int unsigned i = 0; i < PAT_MAX; i++) begin
            if (!has_star && PK_W'(i) < pat_len_q && pat_q[i][7:0] == 8'h2A) begin
                has_star = 1'b1;
                star_pos = PK_W'(i);
            end
        end
        p_lo = caret ? PK_W'(1) : '0;
        q_hi = dollar ? last : pat_len_q;
        p_hi = has_star ? star_pos : q_hi;
        q_lo = star_pos + PK_W'(1);

        // One compare datapath shared by SCAN (prefix at s) and SEEK (suffix at t)
        if (state_q == SEEK) begin
            base = t_q;
            lo   = q_lo;
        end else begin
            base = s_q;
            lo   = p_lo;
        end
        off      = k_q - lo;
        pos      = base + IW'(off);
        str_c    = str_q[pos[IDX_W-1:0]];
        pat_c    = pat_q[k_q[PI_W-1:0]];
        char_ok  = (pos < str_len_q) && (pat_c[7:0] == 8'h2E || fold(str_c) == fold(pat_c));
        end_ok   = !dollar || pos == str_len_q || (pos < str_len_q && str_c[7:0] == 8'h20);
        s_m1     = s_q[IDX_W-1:0] - IDX_W'(1);
        prev_c   = str_q[s_m1];
        start_ok = !caret || s_q == '0 || prev_c[7:0] == 8'h20;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            for (int unsigned i = 0; i < STR_MAX; i++) str_q[i] <= '0;
            for (int unsigned i = 0; i < PAT_MAX; i++) pat_q[i] <= '0;
            str_len_q <= '0;
            pat_len_q <= '0;
            s_q       <= '0;
            t_q       <= '0;
            k_q       <= '0;
            valid_q   <= 1'b0;
            match_q   <= 1'b0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            match_q <= 1'b0;
            idx_q   <= '0;
            case (state_q)
                IDLE: begin
                    if (isstring) begin
                        for (int unsigned i = 0; i < STR_MAX; i++) str_q[i] <= '0;
                        str_q[0]  <= chardata;
                        str_len_q <= IW'(1);
                        state_q   <= LD_STR;
                    end else if (ispattern) begin
                        pat_q[0]  <= chardata;
                        pat_len_q <= PK_W'(1);
                        state_q   <= LD_PAT;
                    end
                end
                LD_STR: begin
                    if (isstring) begin
                        if (str_len_q < IW'(STR_MAX)) begin
                            str_q[str_len_q[IDX_W-1:0]] <= chardata;
                            str_len_q <= str_len_q + IW'(1);
                        end
                    end else if (ispattern) begin
                        pat_q[0]  <= chardata;
                        pat_len_q <= PK_W'(1);
                        state_q   <= LD_PAT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                LD_PAT: begin
                    if (ispattern) begin
                        if (!isstring && pat_len_q < PK_W'(PAT_MAX)) begin
                            pat_q[pat_len_q[PI_W-1:0]] <= chardata;
                            pat_len_q <= pat_len_q + PK_W'(1);
                        end
                    end else begin
                        state_q <= SCAN;
                        busy_q  <= 1'b1;
                        s_q     <= '0;
                        k_q     <= p_lo;
                    end
                end
                SCAN: begin
                    if (s_q >= str_len_q) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (k_q == p_hi) begin
                        if (start_ok && has_star) begin
                            state_q <= SEEK;
                            t_q     <= pos;
                            k_q     <= q_lo;
                        end else if (start_ok && end_ok) begin
                            state_q <= DONE;
                            valid_q <= 1'b1;
                            match_q <= 1'b1;
                            idx_q   <= s_q[IDX_W-1:0];
                            busy_q  <= 1'b0;
                        end else begin
                            s_q <= s_q + IW'(1);
                            k_q <= p_lo;
                        end
                    end else if (char_ok) begin
                        k_q <= k_q + PK_W'(1);
                    end else begin
                        s_q <= s_q + IW'(1);
                        k_q <= p_lo;
                    end
                end
                SEEK: begin
                    // Suffix absent at every t >= s+|P| means it is absent for every later s
                    // too, so exhaustion ends the search instead of rescanning.
                    if (t_q > str_len_q) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (k_q == q_hi) begin
                        if (end_ok) begin
                            state_q <= DONE;
                            valid_q <= 1'b1;
                            match_q <= 1'b1;
                            idx_q   <= s_q[IDX_W-1:0];
                            busy_q  <= 1'b0;
                        end else begin
                            t_q <= t_q + IW'(1);
                            k_q <= q_lo;
                        end
                    end else if (char_ok) begin
                        k_q <= k_q + PK_W'(1);
                    end else begin
                        t_q <= t_q + IW'(1);
                        k_q <= q_lo;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign valid       = valid_q;
    assign match       = match_q;
    assign match_index = idx_q;
    assign busy        = busy_q;
endmodule
